debug_uart_host: RTL
====================

// Module: debug_uart_host
// PURPOSE
// - Initiator end of the debug_uart ASCII line protocol. Turns a local bus request into a UART command line.
// - Command format: "AAAAAAAA\n" for a read, "AAAAAAAA DDDDDDDD\n" for a write.
// - Parses the returned line and presents it as a single-beat response.
// - Placed in a test or host FPGA that drives a remote debug_uart slave. One request outstanding at a time.
// PARAMETERS
// - UART_CLK_DIV  434      clk cycles per UART bit (baud = clk/UART_CLK_DIV), must be >= 8
// - AWIDTH        4        address width in bytes (command carries AWIDTH*2 hex digits)
// - DWIDTH        4        data width in bytes (command/response carries DWIDTH*2 hex digits)
// - RESP_TIMEOUT  5000000  clk cycles to wait for the response LF, counted from the end of the command's stop bit
// PORTS
// - clk          in   1          clock
// - rstn         in   1          asynchronous reset, active-low
// - i_uart_rx    in   1          UART line from remote (async, synchronised internally)
// - o_uart_tx    out  1          UART line to remote; idle high
// - req_valid    in   1          request valid
// - req_ready    out  1          high only in IDLE; handshake = req_valid & req_ready
// - req_write    in   1          1 = write, 0 = read
// - req_addr     in   AWIDTH*8   address
// - req_wdata    in   DWIDTH*8   write data (ignored on read)
// - rsp_valid    out  1          one-cycle response pulse
// - rsp_status   out  2          0 OK, 1 REMOTE_TIMEOUT, 2 REMOTE_INVALID, 3 ERROR (local timeout / malformed)
// - rsp_rdata    out  DWIDTH*8   read data; 0 unless read with status OK
// BEHAVIOUR
// - Reset values:
//   - o_uart_tx=1, rsp_valid=0, rsp_status=0, rsp_rdata=0.
//   - FSM=IDLE, so req_ready=1 while rstn is low and after release.
//   - Reset mid-operation aborts everything: a partial TX frame is cut off with the line high, and no rsp_valid is issued.
// - FSM states and transitions:
//   - IDLE: on handshake, latch the request -> SEND.
//   - SEND -> WAIT after the last stop bit.
//   - WAIT -> RESP on LF, or on timer == RESP_TIMEOUT.
//   - RESP lasts one cycle: rsp_valid=1 -> IDLE. Next req_ready is in the cycle after rsp_valid.
// - TX framing:
//   - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each bit UART_CLK_DIV cycles, bytes back-to-back.
//   - Hex digits are uppercase ASCII, MSB nibble first, all leading zeros sent.
//   - Write: exactly one 0x20 separates address and data.
//   - Terminator is 0x0A.
//   - Byte counts: read = AWIDTH*2+1, write = AWIDTH*2+DWIDTH*2+2.
// - RX framing:
//   - 2-flop synchroniser, then falling-edge start detect.
//   - Start bit re-checked low at half-bit; if not low, treat as a glitch and go back to hunting.
//   - Data sampled at mid-bit.
//   - Stop bit = 0: byte dropped and a sticky line-error flag set for the current response.
//   - Bytes completing outside WAIT are discarded.
// - Response parse (WAIT):
//   - 0x0D ignored; 0x0A ends the line.
//   - Other bytes increment a character count that saturates at 15.
//   - The last 7 bytes are kept in a shift register.
//   - Hex characters (0-9, a-f, A-F) shift into a DWIDTH*8 accumulator; a non-hex byte clears an all-hex flag.
// - Classification at LF, first match wins:
//   - Line-error flag set -> 3.
//   - Line is "timeout" -> 1.
//   - Line is "invalid" -> 2.
//   - Write request and line is "wr done" -> 0.
//   - Read request, count == DWIDTH*2 and all-hex -> 0, with rsp_rdata = accumulator.
//   - Anything else, including an empty line or an overlong line -> 3.
// - Local timeout:
//   - A 32-bit timer is cleared on entry to WAIT.
//   - Reaching RESP_TIMEOUT -> status 3.
//   - If a byte completes in the same cycle as the timeout, the timeout wins and the byte is ignored.
// - req_* inputs are sampled only at the handshake; later changes have no effect.
// STRUCTURE
// - Package debug_uart_pkg:
//   - typedef enum logic[1:0] rsp_status_t {ST_OK, ST_RTIMEOUT, ST_INVALID, ST_ERROR}.
//   - ASCII constants (LF, CR, SP).
//   - MSG_TIMEOUT, MSG_INVALID, MSG_WR_DONE (7-char strings).
//   - Functions ishexdigit, ascii2hex, hex2ascii; debug_uart is to use the same package.
// - Sub-module uart_byte_rx (UART_CLK_DIV):
//   - Ports: clk, rstn, i_rx, o_valid, o_data[7:0], o_ferr.
// - TX serialiser, command formatter and parser stay in this module.
// TESTING (UART_CLK_DIV=8, AWIDTH=DWIDTH=4, remote = debug_uart + RAM model, unless noted)
// 1. Write 0x00000010 = 0xDEADBEEF -> TX bytes "00000010 DEADBEEF\n" (18 bytes), remote replies "wr done\n"
//    -> rsp_status=0, RAM[0x10] = 0xDEADBEEF.
// 2. Read 0x00000010 -> TX "00000010\n".
//    Remote replies "DEADBEEF\n" -> rsp_rdata=0xDEADBEEF, status 0.
//    Scripted reply "deadbeef\r\n" -> same result.
// 3. Remote bus never ready -> reply "timeout\n" -> status 1, rsp_rdata=0.
//    Scripted "invalid\n" -> 2. Scripted "garbage\n" -> 3.
//    Read answered with "wr done\n" -> 3.
// 4. No reply, RESP_TIMEOUT=1000 -> rsp_valid exactly 1001 cycles after the LF stop bit ends, status 3, req_ready follows.
// 5. Reply with a corrupted stop bit in byte 3 -> status 3. Next request completes normally.
// 6. rstn low in the middle of the 5th TX byte -> o_uart_tx=1 at once, no rsp_valid.
//    After release, req_ready=1 and a new read returns correct data.

Source files
------------

// File: rtl/debug_uart_pkg.sv
// Shared definitions for both ends of the debug_uart ASCII line protocol:
// response codes, fixed reply strings and hex/ASCII helpers.
package debug_uart_pkg;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_RTIMEOUT = 2'd1,
        ST_INVALID  = 2'd2,
        ST_ERROR    = 2'd3
    } rsp_status_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_SP = 8'h20;

    // First character sits in the top byte, matching a left-shifting tail register.
    localparam logic [55:0] MSG_TIMEOUT = "timeout";
    localparam logic [55:0] MSG_INVALID = "invalid";
    localparam logic [55:0] MSG_WR_DONE = "wr done";

    function automatic logic ishexdigit(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h46)) ||
               ((c >= 8'h61) && (c <= 8'h66));
    endfunction

    // Letters of either case share the same low nibble offset (A=0x41, a=0x61).
    function automatic logic [3:0] ascii2hex(input logic [7:0] c);
        if (c <= 8'h39)
            return c[3:0];
        else
            return c[3:0] + 4'd9;
    endfunction

    function automatic logic [7:0] hex2ascii(input logic [3:0] n);
        if (n < 4'd10)
            return {4'h3, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8N1, synchronised input, start bit re-checked at half-bit,
// data sampled mid-bit. o_valid pulses once per frame with the stop-bit result.
module uart_byte_rx #(
    parameter int UART_CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_ferr
);
    localparam int CW = $clog2(UART_CLK_DIV);

    typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t      state_reg, state_next;
    logic [2:0]     sync_reg;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [2:0]     bit_reg, bit_next;
    logic [7:0]     data_reg, data_next;
    logic           valid_reg, valid_next;
    logic           ferr_reg, ferr_next;
    logic           rx;
    logic           half_end;
    logic           full_end;

    assign rx       = sync_reg[1];
    assign half_end = cnt_reg == CW'(UART_CLK_DIV / 2 - 1);
    assign full_end = cnt_reg == CW'(UART_CLK_DIV - 1);

    // sync_reg[2] is the previous synchronised sample, used for falling-edge detect.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_reg  <= 3'b111;
            state_reg <= RX_HUNT;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[1:0], i_rx};
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CW'(1);
        bit_next   = bit_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ferr_next  = ferr_reg;
        case (state_reg)
            RX_HUNT: begin
                cnt_next = '0;
                if (sync_reg[2] && !rx)
                    state_next = RX_START;
            end
            RX_START: begin
                if (half_end) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    state_next = rx ? RX_HUNT : RX_DATA;
                end
            end
            RX_DATA: begin
                if (full_end) begin
                    cnt_next  = '0;
                    data_next = {rx, data_reg[7:1]};
                    bit_next  = bit_reg + 3'd1;
                    if (bit_reg == 3'd7)
                        state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (full_end) begin
                    cnt_next   = '0;
                    valid_next = 1'b1;
                    ferr_next  = !rx;
                    state_next = RX_HUNT;
                end
            end
            default: state_next = RX_HUNT;
        endcase
    end

    assign o_valid = valid_reg;
    assign o_data  = data_reg;
    assign o_ferr  = ferr_reg;

endmodule

// File: rtl/debug_uart_host.sv
// Initiator of the debug_uart line protocol: formats one bus request as an ASCII
// command, transmits it, then parses the reply line into a single-beat response.
module debug_uart_host
    import debug_uart_pkg::*;
#(
    parameter int UART_CLK_DIV = 434,
    parameter int AWIDTH       = 4,
    parameter int DWIDTH       = 4,
    parameter int RESP_TIMEOUT = 5000000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_uart_rx,
    output logic                  o_uart_tx,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [AWIDTH*8-1:0]   req_addr,
    input  logic [DWIDTH*8-1:0]   req_wdata,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_status,
    output logic [DWIDTH*8-1:0]   rsp_rdata
);
    localparam int AD    = AWIDTH * 2;
    localparam int DD    = DWIDTH * 2;
    localparam int NB_RD = AD + 1;
    localparam int NB_WR = AD + DD + 2;
    localparam int BW    = $clog2(NB_WR);
    localparam int CW    = $clog2(UART_CLK_DIV);
    localparam int AB    = AWIDTH * 8;
    localparam int DB    = DWIDTH * 8;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_RESP} state_t;

    state_t         state_reg, state_next;
    logic           write_reg;
    logic [AB-1:0]  addr_sh_reg;
    logic [DB-1:0]  wdata_sh_reg;
    logic [BW-1:0]  byte_idx_reg;
    logic [3:0]     bit_idx_reg;
    logic [CW-1:0]  baud_reg;
    logic           tx_reg;
    logic [31:0]    timer_reg;
    logic [3:0]     char_cnt_reg;
    logic [55:0]    tail_reg;
    logic [DB-1:0]  acc_reg;
    logic           all_hex_reg;
    logic           line_err_reg;
    rsp_status_t    rsp_status_reg;
    logic [DB-1:0]  rsp_rdata_reg;

    logic           rx_valid;
    logic [7:0]     rx_data;
    logic           rx_ferr;
    logic [7:0]     cur_byte;
    logic           last_byte;
    logic           baud_end;
    logic           tx_done;
    logic           timed_out;
    logic           line_end;
    logic           is_timeout, is_invalid, is_wr_done;
    rsp_status_t    class_status;
    logic [DB-1:0]  class_rdata;

    uart_byte_rx #(
        .UART_CLK_DIV (UART_CLK_DIV)
    ) u_rx (
        .clk     (clk),
        .rstn    (rstn),
        .i_rx    (i_uart_rx),
        .o_valid (rx_valid),
        .o_data  (rx_data),
        .o_ferr  (rx_ferr)
    );

    // Address and data are consumed from shift registers, MSB nibble first.
    always_comb begin
        if (byte_idx_reg < BW'(AD))
            cur_byte = hex2ascii(addr_sh_reg[AB-1 -: 4]);
        else if (write_reg && byte_idx_reg == BW'(AD))
            cur_byte = ASCII_SP;
        else if (write_reg && byte_idx_reg < BW'(AD + DD + 1))
            cur_byte = hex2ascii(wdata_sh_reg[DB-1 -: 4]);
        else
            cur_byte = ASCII_LF;
    end

    assign last_byte = byte_idx_reg == (write_reg ? BW'(NB_WR - 1) : BW'(NB_RD - 1));
    assign baud_end  = baud_reg == CW'(UART_CLK_DIV - 1);
    assign tx_done   = (state_reg == S_SEND) && baud_end && (bit_idx_reg == 4'd9) && last_byte;
    assign timed_out = timer_reg == 32'(RESP_TIMEOUT);
    assign line_end  = (state_reg == S_WAIT) && !timed_out && rx_valid && !rx_ferr &&
                       (rx_data == ASCII_LF);

    assign is_timeout = (char_cnt_reg == 4'd7) && (tail_reg == MSG_TIMEOUT);
    assign is_invalid = (char_cnt_reg == 4'd7) && (tail_reg == MSG_INVALID);
    assign is_wr_done = (char_cnt_reg == 4'd7) && (tail_reg == MSG_WR_DONE);

    always_comb begin
        class_rdata = '0;
        if (line_err_reg)
            class_status = ST_ERROR;
        else if (is_timeout)
            class_status = ST_RTIMEOUT;
        else if (is_invalid)
            class_status = ST_INVALID;
        else if (write_reg && is_wr_done)
            class_status = ST_OK;
        else if (!write_reg && (char_cnt_reg == 4'(DD)) && all_hex_reg) begin
            class_status = ST_OK;
            class_rdata  = acc_reg;
        end else
            class_status = ST_ERROR;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = S_SEND;
            end
            S_SEND: if (tx_done) state_next = S_WAIT;
            S_WAIT: if (timed_out || line_end) state_next = S_RESP;
            S_RESP: begin
                rsp_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            write_reg      <= 1'b0;
            addr_sh_reg    <= '0;
            wdata_sh_reg   <= '0;
            byte_idx_reg   <= '0;
            bit_idx_reg    <= '0;
            baud_reg       <= '0;
            tx_reg         <= 1'b1;
            timer_reg      <= '0;
            char_cnt_reg   <= '0;
            tail_reg       <= '0;
            acc_reg        <= '0;
            all_hex_reg    <= 1'b1;
            line_err_reg   <= 1'b0;
            rsp_status_reg <= ST_OK;
            rsp_rdata_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid) begin
                        write_reg    <= req_write;
                        addr_sh_reg  <= req_addr;
                        wdata_sh_reg <= req_wdata;
                        byte_idx_reg <= '0;
                        bit_idx_reg  <= '0;
                        baud_reg     <= '0;
                        tx_reg       <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (!baud_end)
                        baud_reg <= baud_reg + CW'(1);
                    else begin
                        baud_reg <= '0;
                        if (bit_idx_reg != 4'd9) begin
                            bit_idx_reg <= bit_idx_reg + 4'd1;
                            tx_reg      <= (bit_idx_reg == 4'd8) ? 1'b1 : cur_byte[bit_idx_reg[2:0]];
                        end else if (last_byte) begin
                            tx_reg       <= 1'b1;
                            timer_reg    <= '0;
                            char_cnt_reg <= '0;
                            tail_reg     <= '0;
                            acc_reg      <= '0;
                            all_hex_reg  <= 1'b1;
                            line_err_reg <= 1'b0;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + BW'(1);
                            bit_idx_reg  <= '0;
                            tx_reg       <= 1'b0;
                            if (byte_idx_reg < BW'(AD))
                                addr_sh_reg <= addr_sh_reg << 4;
                            else if (byte_idx_reg > BW'(AD))
                                wdata_sh_reg <= wdata_sh_reg << 4;
                        end
                    end
                end
                S_WAIT: begin
                    timer_reg <= timer_reg + 32'd1;
                    // A byte landing on the timeout cycle is ignored.
                    if (!timed_out && rx_valid) begin
                        if (rx_ferr)
                            line_err_reg <= 1'b1;
                        else if (rx_data != ASCII_LF && rx_data != ASCII_CR) begin
                            if (char_cnt_reg != 4'd15)
                                char_cnt_reg <= char_cnt_reg + 4'd1;
                            tail_reg <= {tail_reg[47:0], rx_data};
                            if (ishexdigit(rx_data))
                                acc_reg <= {acc_reg[DB-5:0], ascii2hex(rx_data)};
                            else
                                all_hex_reg <= 1'b0;
                        end
                    end
                    if (timed_out) begin
                        rsp_status_reg <= ST_ERROR;
                        rsp_rdata_reg  <= '0;
                    end else if (line_end) begin
                        rsp_status_reg <= class_status;
                        rsp_rdata_reg  <= class_rdata;
                    end
                end
                S_RESP: begin
                    rsp_status_reg <= ST_OK;
                    rsp_rdata_reg  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign o_uart_tx  = tx_reg;
    assign rsp_status = rsp_status_reg;
    assign rsp_rdata  = rsp_rdata_reg;

endmodule
